// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and the next-PC priority decode for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_INC    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_CALL   = 3'd4,
    SEL_RET    = 3'd5
  } pc_sel_e;

  // Exactly one action per cycle; lower-priority requests are dropped.
  function automatic pc_sel_e pc_decode(input logic stall,
                                        input logic ret_en,
                                        input logic call_en,
                                        input logic jump_en,
                                        input logic branch_en);
    pc_sel_e sel;
    if (stall)          sel = SEL_HOLD;
    else if (ret_en)    sel = SEL_RET;
    else if (call_en)   sel = SEL_CALL;
    else if (jump_en)   sel = SEL_JUMP;
    else if (branch_en) sel = SEL_BRANCH;
    else                sel = SEL_INC;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Request and status bundle between fetch control and pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int AWIDTH    = 6,
  parameter int RAS_DEPTH = 4
);
  logic                           stall;
  logic                           branch_en;
  logic [AWIDTH-1:0]              branch_off;
  logic                           jump_en;
  logic                           call_en;
  logic                           ret_en;
  logic [AWIDTH-1:0]              jump_addr;
  logic [AWIDTH-1:0]              pc;
  logic [AWIDTH-1:0]              pc_plus;
  logic [$clog2(RAS_DEPTH):0]     ras_count;
  logic                           ras_empty;
  logic                           ras_full;
  logic                           ras_ovf;
  logic                           ret_err;

  modport master (
    output stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr,
    input  pc, pc_plus, ras_count, ras_empty, ras_full, ras_ovf, ret_err
  );

  modport slave (
    input  stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr,
    output pc, pc_plus, ras_count, ras_empty, ras_full, ras_ovf, ret_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack; a push while full overwrites the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
  parameter int AWIDTH    = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [AWIDTH-1:0]             push_data,
  output logic [AWIDTH-1:0]             top,
  output logic [$clog2(RAS_DEPTH):0]    count,
  output logic                          full,
  output logic                          empty,
  output logic                          ovf
);

  localparam int c_ptr_w = $clog2(RAS_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RAS_DEPTH);

  logic [AWIDTH-1:0]  mem_q [RAS_DEPTH];
  logic [AWIDTH-1:0]  mem_d [RAS_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;

  // The write pointer always sits on the oldest slot once full, so a plain
  // wrapping pointer gives the overwrite-oldest behaviour for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      if (full) ovf_d   = 1'b1;
      else      count_d = count_q + c_cnt_w'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - c_ptr_w'(1);
      count_d  = count_q - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[wr_ptr_q - c_ptr_w'(1)];
  assign count = count_q;
  assign full  = (count_q == c_depth);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program counter with branch/jump/call/return and return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int AWIDTH     = 6,
  parameter int STEP       = 1,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [AWIDTH-1:0] c_step       = AWIDTH'(STEP);
  localparam logic [AWIDTH-1:0] c_reset_addr = AWIDTH'(RESET_ADDR);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              ret_err_q, ret_err_d;
  logic [AWIDTH-1:0] pc_plus;
  logic [AWIDTH-1:0] ras_top;
  logic              ras_empty;
  logic              push, pop;
  pc_sel_e           sel;

  assign pc_plus = pc_q + c_step;
  assign sel     = pc_decode(bus.stall, bus.ret_en, bus.call_en,
                             bus.jump_en, bus.branch_en);

  // Branch offset has the same width as pc, so modular add equals sign-extended add.
  always_comb begin
    pc_d      = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    ret_err_d = 1'b0;
    case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_INC:    pc_d = pc_plus;
      SEL_BRANCH: pc_d = pc_q + bus.branch_off;
      SEL_JUMP:   pc_d = bus.jump_addr;
      SEL_CALL: begin
        pc_d = bus.jump_addr;
        push = 1'b1;
      end
      SEL_RET: begin
        if (ras_empty) begin
          pc_d      = pc_plus;
          ret_err_d = 1'b1;
        end else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      default:    pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= c_reset_addr;
      ret_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ret_err_q <= ret_err_d;
    end
  end

  pc_ras #(
    .AWIDTH    (AWIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .count     (bus.ras_count),
    .full      (bus.ras_full),
    .empty     (ras_empty),
    .ovf       (bus.ras_ovf)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.ras_empty = ras_empty;
  assign bus.ret_err   = ret_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer (AWIDTH=6, STEP=1, RAS_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.AWIDTH(6), .RAS_DEPTH(4)) bus ();

  pc_sequencer #(
    .AWIDTH     (6),
    .STEP       (1),
    .RAS_DEPTH  (4),
    .RESET_ADDR (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.branch_en = 1'b0; bus.jump_en = 1'b0;
    bus.call_en = 1'b0; bus.ret_en = 1'b0;
  endtask

  task automatic go_to(input logic [5:0] a);
    idle();
    bus.jump_en   = 1'b1;
    bus.jump_addr = a;
    tick();
    idle();
  endtask

  task automatic do_call(input logic [5:0] a);
    idle();
    bus.call_en   = 1'b1;
    bus.jump_addr = a;
    tick();
    idle();
  endtask

  task automatic do_ret();
    idle();
    bus.ret_en = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.branch_off = '0;
    bus.jump_addr  = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_pc", bus.pc, 0);
    chk("rst_pc_plus", bus.pc_plus, 1);
    chk("rst_count", bus.ras_count, 0);
    chk("rst_empty", bus.ras_empty, 1);
    chk("rst_full", bus.ras_full, 0);
    chk("rst_ovf", bus.ras_ovf, 0);
    chk("rst_ret_err", bus.ret_err, 0);
    rst = 1'b0;

    // Sequential increment
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("inc_%0d", i), bus.pc, i);
    end
    rst = 1'b1; bus.stall = 1'b1;
    tick();
    chk("rst_over_stall", bus.pc, 0);
    rst = 1'b0; bus.stall = 1'b0;

    // Branch backward and wrap-around
    go_to(6'd10);
    chk("jump_10", bus.pc, 10);
    bus.branch_en = 1'b1; bus.branch_off = 6'h3C;
    tick();
    idle();
    chk("branch_neg4", bus.pc, 6);
    go_to(6'd62);
    tick();
    chk("inc_63", bus.pc, 63);
    tick();
    chk("wrap_0", bus.pc, 0);
    chk("wrap_pc_plus", bus.pc_plus, 1);

    // Call then immediate return
    go_to(6'd4);
    do_call(6'd20);
    chk("call_pc", bus.pc, 20);
    chk("call_count", bus.ras_count, 1);
    do_ret();
    chk("ret_pc", bus.pc, 5);
    chk("ret_count", bus.ras_count, 0);
    chk("ret_empty", bus.ras_empty, 1);

    // Five nested calls overflow a 4-deep stack
    go_to(6'd1);
    do_call(6'd10); tick();
    chk("nest_pc11", bus.pc, 11);
    do_call(6'd20); tick();
    do_call(6'd30); tick();
    do_call(6'd40);
    chk("nest4_full", bus.ras_full, 1);
    chk("nest4_ovf", bus.ras_ovf, 0);
    tick();
    chk("nest_pc41", bus.pc, 41);
    do_call(6'd50);
    chk("nest5_pc", bus.pc, 50);
    chk("nest5_count", bus.ras_count, 4);
    chk("nest5_full", bus.ras_full, 1);
    chk("nest5_ovf", bus.ras_ovf, 1);
    do_ret(); chk("pop_42", bus.pc, 42);
    chk("pop_42_count", bus.ras_count, 3);
    do_ret(); chk("pop_32", bus.pc, 32);
    do_ret(); chk("pop_22", bus.pc, 22);
    do_ret(); chk("pop_12", bus.pc, 12);
    chk("pop_empty", bus.ras_empty, 1);
    chk("pop_no_err", bus.ret_err, 0);
    do_ret();
    chk("underflow_pc", bus.pc, 13);
    chk("underflow_err", bus.ret_err, 1);
    chk("underflow_count", bus.ras_count, 0);
    tick();
    chk("err_pulse_end", bus.ret_err, 0);
    chk("err_after_pc", bus.pc, 14);
    chk("ovf_sticky", bus.ras_ovf, 1);

    // Priority: ret beats call and branch; call beats jump
    go_to(6'd8);
    do_call(6'd30);
    chk("prio_setup_count", bus.ras_count, 1);
    bus.ret_en = 1'b1; bus.call_en = 1'b1; bus.branch_en = 1'b1;
    bus.jump_addr = 6'd50; bus.branch_off = 6'd3;
    tick();
    idle();
    chk("prio_ret_pc", bus.pc, 9);
    chk("prio_ret_no_push", bus.ras_count, 0);
    bus.call_en = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 6'd33;
    tick();
    idle();
    chk("prio_call_pc", bus.pc, 33);
    chk("prio_call_push", bus.ras_count, 1);

    // Stall holds state and drops requests
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 6'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_pc_%0d", i), bus.pc, 33);
      chk($sformatf("stall_count_%0d", i), bus.ras_count, 1);
    end
    bus.stall = 1'b0;
    tick();
    idle();
    chk("unstall_jump", bus.pc, 7);

    // Reset mid-sequence discards the stack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_count", bus.ras_count, 0);
    chk("rst2_ovf", bus.ras_ovf, 0);
    do_ret();
    chk("rst2_ret_pc", bus.pc, 1);
    chk("rst2_ret_err", bus.ret_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the 32-bit processor fetch stage. It holds the instruction-memory word address and selects the next address each cycle: sequential increment, PC-relative branch, absolute jump, call (jump plus push), or return (pop). A small circular return-address stack supports calls and returns. The block replaces the plain address register and feeds the instruction-memory address port directly.

## Interface
- AWIDTH, 6, PC / instruction-memory address width in bits
- STEP, 1, sequential increment added to PC each unstalled cycle
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2
- RESET_ADDR, 0, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and stack; all other requests ignored
- branch_en  in  1  take PC-relative branch
- branch_off  in  AWIDTH  signed two's-complement branch offset
- jump_en  in  1  absolute jump to jump_addr
- call_en  in  1  jump to jump_addr and push pc+STEP
- ret_en  in  1  pop stack top into PC
- jump_addr  in  AWIDTH  absolute target for jump/call
- pc  out  AWIDTH  current fetch address, registered
- pc_plus  out  AWIDTH  pc+STEP, combinational from pc
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries
- ras_empty  out  1  ras_count==0
- ras_full  out  1  ras_count==RAS_DEPTH
- ras_ovf  out  1  sticky: a push occurred while full
- ret_err  out  1  registered one-cycle pulse: return attempted on empty stack

## Operation
- Reset: pc=RESET_ADDR, ras_count=0, ras_ovf=0, ret_err=0; stack contents don't-care. Reset overrides stall and all requests.
- Stall=1: pc, stack, ras_ovf hold; ret_err cleared to 0.
- Unstalled priority, highest first: ret_en > call_en > jump_en > branch_en > increment. Exactly one action per cycle; lower-priority requests are dropped, not queued.
- ret_en, stack non-empty: pc<=top; ras_count-1.
- ret_en, stack empty: pc<=pc+STEP; ret_err<=1 next cycle; stack unchanged.
- call_en: pc<=jump_addr; push pc+STEP. If full, the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, ras_ovf<=1.
- jump_en: pc<=jump_addr.
- branch_en: pc<=pc+sign_extend(branch_off).
- None: pc<=pc+STEP.
- Arithmetic is modulo 2^AWIDTH; wrap-around is silent (max address+STEP -> wraps low).
- ret_err is 0 in every cycle not immediately following a failed return.

## Timing
- All redirects take effect one cycle after the request edge; pc is never combinationally affected by inputs.
- pc_plus tracks pc with zero latency.
- Call then immediate return in the following cycle returns to call-site pc+STEP (push visible to next-cycle pop).
- Stack flags (ras_count/empty/full/ovf) update on the same edge as pc.
- Reset mid-sequence discards all stack entries; first post-reset return raises ret_err.

## Structure
- Package pc_pkg: enum pc_sel_e {SEL_HOLD, SEL_INC, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET}; combinational priority decode produces one pc_sel_e per cycle.
- Sub-module pc_ras: circular return-address stack (push, pop, top, count, full, empty, ovf), parameters AWIDTH and RAS_DEPTH, same clk/rst.
- Top: priority decode, next-PC mux, pc register, ret_err register.

## Test plan
- Reset then 5 unstalled idle cycles, AWIDTH=6 -> pc 0,1,2,3,4,5; asserting rst at pc=5 -> pc=0 next cycle even with stall=1.
- pc=10, branch_en, branch_off=6'h3C (-4) -> pc=6; pc=62, idle twice -> pc=63 then 0 (wrap).
- pc=4, call_en, jump_addr=20 -> pc=20, ras_count=1; next cycle ret_en -> pc=5, ras_count=0.
- Five nested calls with RAS_DEPTH=4 from pc 1,11,21,31,41 -> ras_full, ras_ovf=1; four returns yield 42,32,22,12; fifth return -> pc+1, ret_err pulse one cycle.
- Same cycle ret_en+call_en+branch_en with stack top 9 -> pc=9, no push; call_en+jump_en -> push occurs.
- stall held 3 cycles with jump_en asserted -> pc and ras_count unchanged; jump taken on first unstalled cycle.
